// File: rtl/load_pkg.sv
// Shared definitions for the load alignment path: func3 encodings, FSM states
// and the word-crossing predicate.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA     = 2'd1,
    SPLIT_LO = 2'd2,
    SPLIT_HI = 2'd3
  } state_e;

  // True when the access spills into the next word.
  function automatic logic is_split(input logic [2:0] func3, input logic [1:0] offset);
    return (((func3 == F3_LH) || (func3 == F3_LHU)) && (offset == 2'd3)) ||
           ((func3 == F3_LW) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte-lane alignment and sign/zero extension of a (possibly two-word) load.
module load_extend
  import load_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] result_o
);

  logic [31:0] word;

  assign word = 32'(data_i >> {offset_i, 3'b000});

  always_comb begin
    result_o = '0;
    case (func3_i)
      F3_LB:   result_o = {{24{word[7]}}, word[7:0]};
      F3_LH:   result_o = {{16{word[15]}}, word[15:0]};
      F3_LW:   result_o = word;
      F3_LBU:  result_o = {24'b0, word[7:0]};
      F3_LHU:  result_o = {16'b0, word[15:0]};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load path between the X-stage address and W-stage writeback: issues reads,
// splits word-crossing loads into two beats and extends the result.
//
// state    | meaning
// IDLE     | no load in flight
// DATA     | single-beat read data arriving, result presented
// SPLIT_LO | first beat arriving, second read issued, pipeline held
// SPLIT_HI | second beat arriving, merged result presented
module load_align_unit
  import load_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid_X_i,
  input  logic [2:0]            func3_X_i,
  input  logic [ADDR_WIDTH-1:0] addr_X_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  mem_re_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  busy_o,
  output logic                  load_valid_W_o,
  output logic [WIDTH-1:0]      load_data_W_o,
  output logic                  misaligned_o
);

  localparam int WA = ADDR_WIDTH - 2;

  state_e          state_q;
  logic [2:0]      func3_q;
  logic [1:0]      offset_q;
  logic            split_q;
  logic [WA-1:0]   word_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hold_q;
  logic            held_q;

  logic              kill;
  logic              in_result;
  logic              accept;
  logic              split_x;
  logic [2*WIDTH-1:0] ext_data;
  logic [WIDTH-1:0]  ext_result;

  // Reset is treated like a flush so a load caught mid-flight never pulses valid.
  assign kill      = rst | flush_i;
  assign in_result = (state_q == DATA) || (state_q == SPLIT_HI);
  assign busy_o    = (state_q == SPLIT_LO) & ~rst;
  assign accept    = load_valid_X_i & ~busy_o & ~stall_i & ~kill;
  assign split_x   = is_split(func3_X_i, addr_X_i[1:0]);

  assign ext_data = (state_q == SPLIT_HI) ? {mem_rdata_i, lo_q}
                                          : {{WIDTH{1'b0}}, mem_rdata_i};

  load_extend u_extend (
    .data_i   (ext_data),
    .offset_i (offset_q),
    .func3_i  (func3_q),
    .result_o (ext_result)
  );

  always_comb begin
    mem_re_o   = 1'b0;
    mem_addr_o = '0;
    if (accept) begin
      mem_re_o   = 1'b1;
      mem_addr_o = addr_X_i[ADDR_WIDTH-1:2];
    end else if ((state_q == SPLIT_LO) && !kill) begin
      mem_re_o   = 1'b1;
      mem_addr_o = word_q + {{(WA-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    load_valid_W_o = 1'b0;
    load_data_W_o  = '0;
    misaligned_o   = 1'b0;
    if (in_result && !kill) begin
      // A split flag seen in DATA means crossing loads are not supported.
      if ((state_q == DATA) && split_q) begin
        misaligned_o = ~held_q;
      end else begin
        load_valid_W_o = 1'b1;
        load_data_W_o  = held_q ? hold_q : ext_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      func3_q  <= '0;
      offset_q <= '0;
      split_q  <= 1'b0;
      word_q   <= '0;
      lo_q     <= '0;
      hold_q   <= '0;
      held_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      held_q  <= 1'b0;
    end else if (state_q == SPLIT_LO) begin
      lo_q    <= mem_rdata_i;
      state_q <= SPLIT_HI;
    end else if (in_result && stall_i) begin
      // Memory data is only valid for one cycle, so freeze the result on entry.
      if (!held_q) begin
        hold_q <= ext_result;
        held_q <= 1'b1;
      end
    end else begin
      held_q <= 1'b0;
      if (accept) begin
        func3_q  <= func3_X_i;
        offset_q <= addr_X_i[1:0];
        split_q  <= split_x;
        word_q   <= addr_X_i[ADDR_WIDTH-1:2];
        state_q  <= (split_x && ALLOW_MISALIGNED) ? SPLIT_LO : DATA;
      end else begin
        state_q <= IDLE;
      end
    end
  end

endmodule
